// File: rtl/fp_mac_pkg.sv
// Shared types and widths for the floating-point MAC sequencing controller.
package fp_mac_pkg;

    localparam int unsigned MANT_W  = 24;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_MUL,
        ST_ALIGN,
        ST_ACC,
        ST_NORM,
        ST_DONE
    } state_e;

    // Alignment decision handed from align_calc to the controller
    typedef struct packed {
        logic               swap;
        logic [SHAMT_W-1:0] shamt;
    } align_t;

endpackage

// File: rtl/fp_mac_ctrl_if.sv
// Operand-pair and result valid/ready handshakes of the MAC controller.
interface fp_mac_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );

endinterface

// File: rtl/fp_mac_ctrl_align_calc.sv
// Exponent comparison and saturated alignment shift for the ALIGN stage.
module align_calc #(
    parameter int unsigned MANT_W = fp_mac_pkg::MANT_W
) (
    input  logic [fp_mac_pkg::EXP_W-1:0] prod_exp,
    input  logic [fp_mac_pkg::EXP_W-1:0] acc_exp,
    input  logic                         first,
    output fp_mac_pkg::align_t           align
);
    import fp_mac_pkg::*;

    localparam logic [EXP_W:0] SAT = (EXP_W+1)'(MANT_W);

    logic           gt;
    logic [EXP_W:0] diff;

    // One extra bit keeps the magnitude free of wrap
    always_comb begin
        gt    = prod_exp > acc_exp;
        diff  = gt ? ({1'b0, prod_exp} - {1'b0, acc_exp})
                   : ({1'b0, acc_exp}  - {1'b0, prod_exp});
        align = '0;
        if (first) begin
            align.swap = 1'b1;
        end else begin
            align.swap  = gt;
            align.shamt = (diff > SAT) ? SHAMT_W'(SAT) : SHAMT_W'(diff);
        end
    end

endmodule

// File: rtl/fp_mac_ctrl.sv
// Sequencing FSM for the FP MAC datapath: MUL -> ALIGN -> ACC -> NORM per term,
// counting terms against a length latched at start, then holding the result.
module fp_mac_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned MANT_W = fp_mac_pkg::MANT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             clr,
    fp_mac_ctrl_if.slave     hs,
    input  logic [7:0]       prod_exp,
    input  logic [7:0]       acc_exp,
    input  logic             mant_msb,
    output logic             mul_en,
    output logic             align_en,
    output logic             acc_en,
    output logic             norm_en,
    output logic             acc_zero,
    output logic             acc_clr,
    output logic             align_swap,
    output logic [4:0]       align_shamt,
    output logic             norm_shr,
    output logic             exp_inc,
    output logic             res_zero,
    output logic             busy,
    output logic [CNT_W-1:0] term_cnt
);
    import fp_mac_pkg::*;

    state_e           state;
    state_e           state_nx;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             first_term;
    align_t           align_res;

    assign cnt_inc    = term_cnt + CNT_W'(1);
    assign first_term = (term_cnt == '0);

    align_calc #(.MANT_W(MANT_W)) u_align_calc (
        .prod_exp (prod_exp),
        .acc_exp  (acc_exp),
        .first    (first_term),
        .align    (align_res)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; clr overrides everything
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nx = (num_terms == '0) ? ST_DONE : ST_WAIT_IN;
                ST_WAIT_IN: if (hs.in_valid) state_nx = ST_MUL;
                ST_MUL:     state_nx = ST_ALIGN;
                ST_ALIGN:   state_nx = ST_ACC;
                ST_ACC:     state_nx = ST_NORM;
                ST_NORM:    state_nx = (cnt_inc == num_q) ? ST_DONE : ST_WAIT_IN;
                ST_DONE:    if (hs.out_ready) state_nx = ST_IDLE;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // Control outputs decoded from the registered state
    always_comb begin
        hs.in_ready  = 1'b0;
        hs.out_valid = 1'b0;
        mul_en       = 1'b0;
        align_en     = 1'b0;
        acc_en       = 1'b0;
        norm_en      = 1'b0;
        acc_zero     = 1'b0;
        align_swap   = 1'b0;
        align_shamt  = '0;
        norm_shr     = 1'b0;
        exp_inc      = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_WAIT_IN: hs.in_ready = 1'b1;
            ST_MUL:     mul_en = 1'b1;
            ST_ALIGN: begin
                align_en    = 1'b1;
                align_swap  = align_res.swap;
                align_shamt = align_res.shamt;
            end
            ST_ACC: begin
                acc_en   = 1'b1;
                acc_zero = first_term;
            end
            ST_NORM: begin
                norm_en  = 1'b1;
                norm_shr = mant_msb;
                exp_inc  = mant_msb;
            end
            ST_DONE:    hs.out_valid = 1'b1;
            default:    ;
        endcase
    end

    // Term counter, latched length, clear pulse and zero-result flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q    <= '0;
            term_cnt <= '0;
            acc_clr  <= 1'b0;
            res_zero <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            if (clr) begin
                term_cnt <= '0;
                acc_clr  <= 1'b1;
                res_zero <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        num_q    <= num_terms;
                        term_cnt <= '0;
                        acc_clr  <= 1'b1;
                        res_zero <= (num_terms == '0);
                    end
                    ST_NORM: term_cnt <= cnt_inc;
                    ST_DONE: if (hs.out_ready) res_zero <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_mac_ctrl.sv
// Randomized, self-checking bench for fp_mac_ctrl against a cycle-schedule reference model.
module tb_fp_mac_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] num_terms;
    logic       clr;
    logic [7:0] prod_exp;
    logic [7:0] acc_exp;
    logic       mant_msb;
    logic       mul_en, align_en, acc_en, norm_en;
    logic       acc_zero, acc_clr, align_swap;
    logic [4:0] align_shamt;
    logic       norm_shr, exp_inc, res_zero, busy;
    logic [7:0] term_cnt;

    fp_mac_ctrl_if hs();

    fp_mac_ctrl #(.CNT_W(8), .MANT_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_terms   (num_terms),
        .clr         (clr),
        .hs          (hs),
        .prod_exp    (prod_exp),
        .acc_exp     (acc_exp),
        .mant_msb    (mant_msb),
        .mul_en      (mul_en),
        .align_en    (align_en),
        .acc_en      (acc_en),
        .norm_en     (norm_en),
        .acc_zero    (acc_zero),
        .acc_clr     (acc_clr),
        .align_swap  (align_swap),
        .align_shamt (align_shamt),
        .norm_shr    (norm_shr),
        .exp_inc     (exp_inc),
        .res_zero    (res_zero),
        .busy        (busy),
        .term_cnt    (term_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int m_tc = 0;
    bit acp = 1'b0;
    bit acp_nx = 1'b0;
    int dir_pe[int];
    int dir_ae[int];
    int dir_mm[int];

    function automatic logic [31:0] pk(input int ir, input int en, input int az, input int acl,
                                       input int sw, input int sh, input int nx, input int rz,
                                       input int ov, input int bz, input int tc);
        return {6'b0, 1'(ir), 4'(en), 1'(az), 1'(acl), 1'(sw), 5'(sh),
                1'(nx), 1'(nx), 1'(rz), 1'(ov), 1'(bz), 8'(tc)};
    endfunction

    function automatic logic [31:0] obs();
        return {6'b0, hs.in_ready, mul_en, align_en, acc_en, norm_en, acc_zero, acc_clr,
                align_swap, align_shamt, norm_shr, exp_inc, res_zero, hs.out_valid, busy, term_cnt};
    endfunction

    // Alignment rule: larger exponent wins, shift by magnitude saturated at the mantissa width
    function automatic void ref_align(input int p, input int a, input bit first,
                                      output int sw, output int sh);
        int d;
        if (first) begin
            sw = 1;
            sh = 0;
        end else begin
            d  = p - a;
            sw = (d > 0) ? 1 : 0;
            if (d < 0) d = -d;
            sh = (d > 24) ? 24 : d;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] exp_v);
        logic [31:0] o;
        o = obs();
        vecs++;
        assert (o === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acp    = acp_nx;
        acp_nx = 1'b0;
    endtask

    // One accumulation: optional input gaps, optional clr in ALIGN of term clr_term, DONE backpressure
    task automatic run_acc(input int n, input int gap_max, input int clr_term, input int hold);
        int g, pe, ae, sw, sh, mm;
        tick();
        start       = 1'b1;
        num_terms   = 8'(n);
        hs.in_valid = 1'($urandom);
        hs.out_ready = 1'b0;
        acp_nx      = 1'b1;
        #1 chk("idle_start", pk(0, 0, 0, int'(acp), 0, 0, 0, 0, 0, 0, m_tc));
        m_tc = 0;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            g = int'($urandom_range(32'(gap_max), 0));
            for (int j = 0; j < g; j++) begin
                hs.in_valid = 1'b0;
                #1 chk("wait_in", pk(1, 0, 0, int'(acp), 0, 0, 0, 0, 0, 1, k));
                tick();
            end
            hs.in_valid = 1'b1;
            #1 chk("handshake", pk(1, 0, 0, int'(acp), 0, 0, 0, 0, 0, 1, k));
            tick();
            hs.in_valid = 1'($urandom);
            #1 chk("mul", pk(0, 8, 0, int'(acp), 0, 0, 0, 0, 0, 1, k));
            tick();
            pe = dir_pe.exists(k) ? dir_pe[k] : int'($urandom_range(255, 0));
            ae = dir_ae.exists(k) ? dir_ae[k] : int'($urandom_range(255, 0));
            prod_exp = 8'(pe);
            acc_exp  = 8'(ae);
            ref_align(pe, ae, (k == 0), sw, sh);
            if (k == clr_term) begin
                clr    = 1'b1;
                acp_nx = 1'b1;
            end
            #1 chk("align", pk(0, 4, 0, int'(acp), sw, sh, 0, 0, 0, 1, k));
            tick();
            if (k == clr_term) begin
                clr  = 1'b0;
                m_tc = 0;
                #1 chk("clr_idle", pk(0, 0, 0, int'(acp), 0, 0, 0, 0, 0, 0, 0));
                return;
            end
            #1 chk("acc", pk(0, 2, (k == 0) ? 1 : 0, int'(acp), 0, 0, 0, 0, 0, 1, k));
            tick();
            mm = dir_mm.exists(k) ? dir_mm[k] : int'($urandom_range(1, 0));
            mant_msb = 1'(mm);
            #1 chk("norm", pk(0, 1, 0, int'(acp), 0, 0, mm, 0, 0, 1, k));
            tick();
            mant_msb = 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            hs.out_ready = 1'b0;
            start        = 1'($urandom);
            #1 chk("done_hold", pk(0, 0, 0, int'(acp), 0, 0, 0, (n == 0) ? 1 : 0, 1, 1, n));
            tick();
        end
        hs.out_ready = 1'b1;
        start        = 1'b0;
        #1 chk("done", pk(0, 0, 0, int'(acp), 0, 0, 0, (n == 0) ? 1 : 0, 1, 1, n));
        tick();
        hs.out_ready = 1'b0;
        m_tc = n;
        #1 chk("idle_after", pk(0, 0, 0, int'(acp), 0, 0, 0, 0, 0, 0, n));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_terms    = '0;
        clr          = 1'b0;
        prod_exp     = '0;
        acc_exp      = '0;
        mant_msb     = 1'b0;
        hs.in_valid  = 1'b0;
        hs.out_ready = 1'b0;
        tick();
        tick();
        #1 chk("reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;

        // Three back-to-back terms: in_ready at 1/6/11, out_valid at 16
        run_acc(3, 0, -1, 1);
        // Zero-length accumulation goes straight to DONE
        run_acc(0, 0, -1, 1);

        dir_pe[1] = 130; dir_ae[1] = 100;
        run_acc(2, 0, -1, 0);
        dir_pe[1] = 100; dir_ae[1] = 130;
        run_acc(2, 0, -1, 0);
        dir_pe[1] = 127; dir_ae[1] = 125; dir_mm[1] = 1;
        run_acc(2, 0, -1, 0);
        dir_pe.delete(); dir_ae.delete(); dir_mm.delete();

        // Abort in ALIGN of the second term, then a clean run
        run_acc(3, 0, 1, 0);
        run_acc(3, 1, -1, 0);

        // Result backpressure with start ignored in DONE
        run_acc(2, 0, -1, 5);

        for (int r = 0; r < 20; r++)
            run_acc(int'($urandom_range(6, 0)), 3, -1, int'($urandom_range(3, 0)));

        // Maximum length: no counter wrap
        run_acc(255, 0, -1, 0);

        // Asynchronous reset mid-run
        tick();
        start     = 1'b1;
        num_terms = 8'd4;
        acp_nx    = 1'b1;
        tick();
        start       = 1'b0;
        hs.in_valid = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1 chk("async_rst", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_n       = 1'b1;
        hs.in_valid = 1'b0;
        m_tc        = 0;
        run_acc(2, 1, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
